// File: rtl/matrix_unloader_if.sv
// Transmit stream of the serial matrix word protocol: one word per
// valid/ready handshake, with tx_ctrl marking header words.
interface matrix_unloader_if #(
    parameter int unsigned DATA_W = 128
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_ctrl;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_ctrl,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_ctrl,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/matrix_unloader.sv
// Buffers a result matrix from the compute engine and streams it out as a
// rows/cols header followed by the elements in row-major order.
module matrix_unloader #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned MAX_ROWS = 3,
    parameter int unsigned MAX_COLS = 3,
    parameter int unsigned DIM_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [DIM_W-1:0]    wr_row_i,
    input  logic [DIM_W-1:0]    wr_col_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                start_i,
    input  logic [DIM_W-1:0]    rows_i,
    input  logic [DIM_W-1:0]    cols_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    matrix_unloader_if.master   tx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR_R = 3'd1,
        HDR_C = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  buf_q [MAX_ROWS][MAX_COLS];
    logic [DIM_W-1:0]   rows_q, cols_q;
    logic [DIM_W-1:0]   row_q, col_q;
    logic [DIM_W-1:0]   row_d, col_d;
    logic [DATA_W-1:0]  tx_data_q;
    logic               tx_ctrl_q, tx_valid_q;
    logic               busy_q, done_q, err_q;

    logic               xfer;
    logic               last_col;
    logic               last_elem;
    logic               wr_ok;
    logic               dims_ok;

    // Handshake qualification and row-major index advance.
    always_comb begin
        xfer      = tx_valid_q & tx.tx_ready;
        last_col  = (col_q == cols_q - DIM_W'(1));
        last_elem = last_col && (row_q == rows_q - DIM_W'(1));
        row_d     = last_col ? row_q + DIM_W'(1) : row_q;
        col_d     = last_col ? '0 : col_q + DIM_W'(1);
        wr_ok     = wr_en_i && !busy_q &&
                    (wr_row_i < DIM_W'(MAX_ROWS)) && (wr_col_i < DIM_W'(MAX_COLS));
        dims_ok   = (rows_i != '0) && (rows_i <= DIM_W'(MAX_ROWS)) &&
                    (cols_i != '0) && (cols_i <= DIM_W'(MAX_COLS));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            tx_data_q  <= '0;
            tx_ctrl_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_ROWS); i++) begin
                for (int j = 0; j < int'(MAX_COLS); j++) begin
                    buf_q[i][j] <= '0;
                end
            end
        end else begin
            err_q <= 1'b0;
            // Writes land before any element read: the first element leaves two transfers after start.
            if (wr_ok) begin
                buf_q[wr_row_i][wr_col_i] <= wr_data_i;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (dims_ok) begin
                            rows_q     <= rows_i;
                            cols_q     <= cols_i;
                            busy_q     <= 1'b1;
                            tx_valid_q <= 1'b1;
                            tx_ctrl_q  <= 1'b1;
                            tx_data_q  <= DATA_W'(rows_i);
                            state_q    <= HDR_R;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HDR_R: begin
                    if (xfer) begin
                        tx_data_q <= DATA_W'(cols_q);
                        state_q   <= HDR_C;
                    end
                end
                HDR_C: begin
                    if (xfer) begin
                        tx_data_q <= buf_q[0][0];
                        tx_ctrl_q <= 1'b0;
                        row_q     <= '0;
                        col_q     <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (last_elem) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            row_q     <= row_d;
                            col_q     <= col_d;
                            tx_data_q <= buf_q[row_d][col_d];
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_ctrl  = tx_ctrl_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_matrix_unloader.sv
// Directed bench for matrix_unloader: a buffer model feeds a scoreboard of
// expected {ctrl,data} words that is drained as the DUT transfers them.
module tb_matrix_unloader;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DIM_W  = 2;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DIM_W-1:0]  wr_row, wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [DIM_W-1:0]  rows, cols;
    logic              busy, done, err;

    matrix_unloader_if #(.DATA_W(DATA_W)) tx_if ();

    matrix_unloader #(
        .DATA_W(DATA_W), .MAX_ROWS(3), .MAX_COLS(3), .DIM_W(DIM_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
        .start_i(start), .rows_i(rows), .cols_i(cols),
        .busy_o(busy), .done_o(done), .err_o(err),
        .tx(tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W-1:0] mem [3][3];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                mem[i][j] = '0;
    endtask

    // Buffer write while idle; out-of-range indices leave the model untouched.
    task automatic wr(input int r, input int c, input logic [DATA_W-1:0] v);
        wr_en = 1'b1; wr_row = DIM_W'(r); wr_col = DIM_W'(c); wr_data = v;
        if (r < 3 && c < 3) mem[r][c] = v;
        tick();
        wr_en = 1'b0;
    endtask

    // mode: 0 ready always, 1 alternating, 2 random. abort_after>0 asserts reset after that many transfers.
    task automatic frame(input int rr, input int cc, input int mode, input int abort_after,
                         input bit poke, input bit co_wr, input logic [DATA_W-1:0] co_val);
        int  n_xfer;
        bit  stalled, finished, aborted;
        logic [DATA_W:0] held, expw;
        if (co_wr) begin
            wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = co_val;
            mem[0][0] = co_val;
        end
        start = 1'b1; rows = DIM_W'(rr); cols = DIM_W'(cc);
        exp_q.push_back({1'b1, DATA_W'(rr)});
        exp_q.push_back({1'b1, DATA_W'(cc)});
        for (int r = 0; r < rr; r++)
            for (int c = 0; c < cc; c++)
                exp_q.push_back({1'b0, mem[r][c]});
        tick();
        start = 1'b0; wr_en = 1'b0;
        chk("busy_after_start", 160'(busy), 160'(1));
        n_xfer = 0; stalled = 0; finished = 0; aborted = 0; held = '0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            tx_if.tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (poke && cyc == 1) begin
                start = 1'b1; rows = 2'd1; cols = 2'd1;
                wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = 128'hDEAD;
            end else if (poke && cyc == 2) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (stalled) chk("stall_hold", 160'({tx_if.tx_ctrl, tx_if.tx_data}), 160'(held));
            chk("valid_in_frame", 160'(tx_if.tx_valid), 160'(1));
            chk("done_in_frame", 160'(done), 160'(0));
            chk("err_in_frame", 160'(err), 160'(0));
            if (tx_if.tx_ready) begin
                expw = exp_q.pop_front();
                chk("word", 160'({tx_if.tx_ctrl, tx_if.tx_data}), 160'(expw));
                n_xfer++;
                stalled = 0;
            end else begin
                held = {tx_if.tx_ctrl, tx_if.tx_data};
                stalled = 1;
            end
            tick();
            if (exp_q.size() == 0) begin
                finished = 1;
            end else if (abort_after > 0 && n_xfer == abort_after) begin
                rst = 1'b1;
                tick();
                chk("abort_valid", 160'(tx_if.tx_valid), 160'(0));
                chk("abort_done", 160'(done), 160'(0));
                chk("abort_busy", 160'(busy), 160'(0));
                rst = 1'b0;
                exp_q.delete();
                clear_mem();
                finished = 1; aborted = 1;
            end
        end
        start = 1'b0; wr_en = 1'b0; tx_if.tx_ready = 1'b0;
        if (!finished) begin
            chk("frame_timeout", 160'(0), 160'(1));
            exp_q.delete();
        end else if (!aborted) begin
            chk("xfer_count", 160'(n_xfer), 160'(rr * cc + 2));
            chk("done_pulse", 160'(done), 160'(1));
            chk("valid_after_last", 160'(tx_if.tx_valid), 160'(0));
            chk("busy_in_done", 160'(busy), 160'(1));
            tick();
            chk("done_cleared", 160'(done), 160'(0));
            chk("busy_cleared", 160'(busy), 160'(0));
        end
    endtask

    initial begin
        clear_mem();
        tx_if.tx_ready = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; rows = '0; cols = '0;
        rst = 1'b1;
        @(negedge clk);

        // Reset with random inputs, then a 3x3 frame of the cleared buffer.
        for (int k = 0; k < 2; k++) begin
            wr_en = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
            wr_row = DIM_W'($urandom_range(0, 3)); wr_col = DIM_W'($urandom_range(0, 3));
            rows = DIM_W'($urandom_range(0, 3)); cols = DIM_W'($urandom_range(0, 3));
            wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tx_if.tx_ready = 1'($urandom_range(0, 1));
            tick();
            chk("rst_valid", 160'(tx_if.tx_valid), 160'(0));
            chk("rst_ctrl", 160'(tx_if.tx_ctrl), 160'(0));
            chk("rst_data", 160'(tx_if.tx_data), 160'(0));
            chk("rst_busy", 160'(busy), 160'(0));
            chk("rst_done", 160'(done), 160'(0));
            chk("rst_err", 160'(err), 160'(0));
        end
        wr_en = 1'b0; start = 1'b0; tx_if.tx_ready = 1'b0;
        rst = 1'b0;
        tick();
        frame(3, 3, 0, 0, 0, 0, '0);

        // 2x3 with ready held high, then with ready alternating.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                wr(r, c, DATA_W'(32'h10 + 3 * r + c));
        frame(2, 3, 0, 0, 0, 0, '0);
        frame(2, 3, 1, 0, 0, 0, '0);

        // Boundaries: 1x1, full 3x3, out-of-range writes ignored.
        frame(1, 1, 0, 0, 0, 0, '0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                wr(r, c, {32'hA5A5_0000 + 32'(r * 16 + c), 96'h1234_5678_9ABC_DEF0_0F0F_F0F0});
        wr(3, 0, 128'hBAD0);
        wr(0, 3, 128'hBAD1);
        frame(3, 3, 2, 0, 0, 0, '0);

        // Invalid dimensions raise err and never start a frame.
        start = 1'b1; rows = 2'd0; cols = 2'd2;
        tick();
        start = 1'b0;
        chk("err_rows0", 160'(err), 160'(1));
        chk("err_rows0_valid", 160'(tx_if.tx_valid), 160'(0));
        chk("err_rows0_busy", 160'(busy), 160'(0));
        tick();
        chk("err_one_cycle", 160'(err), 160'(0));
        start = 1'b1; rows = 2'd2; cols = 2'd0;
        tick();
        start = 1'b0;
        chk("err_cols0", 160'(err), 160'(1));
        chk("err_cols0_valid", 160'(tx_if.tx_valid), 160'(0));
        tick();

        // start and wr_en while busy are ignored; write together with start is sent.
        frame(2, 2, 0, 0, 1, 0, '0);
        frame(2, 2, 0, 0, 0, 0, '0);
        frame(2, 2, 1, 0, 0, 1, 128'hC0FFEE);

        // Reset mid-frame after three elements, then a fresh frame from the header.
        tx_if.tx_ready = 1'b0;
        frame(3, 3, 0, 5, 0, 0, '0);
        wr(1, 1, 128'h77);
        wr(0, 1, 128'h55);
        frame(2, 2, 1, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
